// File: rtl/gc_trap_controller.sv
// gc_trap_controller: global trap/return arbitration, pipeline drain, front-end
// flush and PC redirect sequencing, plus post-reset init-clear.
// Optional build macro: GC_TRAP_STATS_EN adds trap_count/ret_count outputs.
module gc_trap_controller #(
    parameter int NUM_SRC          = 4,
    parameter int ID_W             = 3,
    parameter int CODE_W           = 5,
    parameter int XLEN             = 32,
    parameter int INIT_CLEAR_DEPTH = 8,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ID_W-1:0]   src_id,
    input  logic [NUM_SRC*CODE_W-1:0] src_code,
    input  logic [NUM_SRC*XLEN-1:0]   src_tval,
    output logic [NUM_SRC-1:0]        src_ack,
    input  logic                      ret_req,
    input  logic [XLEN-1:0]           ret_pc,
    output logic                      ret_ack,
    input  logic [XLEN-1:0]           trap_vec,
    input  logic                      drain_done,
    output logic                      init_clear,
    output logic                      fetch_hold,
    output logic                      issue_hold,
    output logic                      fetch_flush,
    output logic                      pc_override,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      exc_valid,
    output logic [CODE_W-1:0]         exc_code,
    output logic [XLEN-1:0]           exc_tval,
    output logic [ID_W-1:0]           exc_id,
    output logic                      busy
`ifdef GC_TRAP_STATS_EN
    ,
    output logic [31:0]               trap_count,
    output logic [31:0]               ret_count
`endif
);

    localparam int CNT_MAX = (INIT_CLEAR_DEPTH > FLUSH_CYCLES) ? INIT_CLEAR_DEPTH : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CLEAR_DEPTH - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt_q;

    // Latched event record
    logic [IDX_W-1:0]    src_idx_q;
    logic                is_trap_q;
    logic [ID_W-1:0]     id_q;
    logic [CODE_W-1:0]   code_q;
    logic [XLEN-1:0]     tval_q;
    logic [XLEN-1:0]     ret_pc_q;

    // Priority-encoder results
    logic                req_any;
    logic [IDX_W-1:0]    req_idx;
    logic [ID_W-1:0]     sel_id;
    logic [CODE_W-1:0]   sel_code;
    logic [XLEN-1:0]     sel_tval;

    logic                take_src;
    logic                take_ret;

    // Pick the lowest-index requesting source and its record fields
    always_comb begin
        req_any  = 1'b0;
        req_idx  = '0;
        sel_id   = '0;
        sel_code = '0;
        sel_tval = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && !req_any) begin
                req_any  = 1'b1;
                req_idx  = IDX_W'(i);
                sel_id   = src_id[i*ID_W +: ID_W];
                sel_code = src_code[i*CODE_W +: CODE_W];
                sel_tval = src_tval[i*XLEN +: XLEN];
            end
        end
    end

    // Next-state and combinational accept decode
    always_comb begin
        state_n  = state_q;
        take_src = 1'b0;
        take_ret = 1'b0;
        src_ack  = '0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == '0) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_any) begin
                    take_src = 1'b1;
                    state_n  = ST_DRAIN;
                end else if (ret_req) begin
                    take_ret = 1'b1;
                    state_n  = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                // Only a strictly older-priority source may replace the record;
                // a replacement holds DRAIN for that cycle even if drained.
                if (req_any && (req_idx < src_idx_q)) begin
                    take_src = 1'b1;
                end else if (drain_done) begin
                    state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_n = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase
        if (take_src) src_ack[req_idx] = 1'b1;
        ret_ack = take_ret;
    end

    // State, counter, event record and registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= INIT_LOAD;
            src_idx_q   <= '0;
            is_trap_q   <= 1'b0;
            id_q        <= '0;
            code_q      <= '0;
            tval_q      <= '0;
            ret_pc_q    <= '0;
            init_clear  <= 1'b1;
            fetch_hold  <= 1'b1;
            issue_hold  <= 1'b1;
            busy        <= 1'b1;
            fetch_flush <= 1'b0;
            pc_override <= 1'b0;
            exc_valid   <= 1'b0;
`ifdef GC_TRAP_STATS_EN
            trap_count  <= '0;
            ret_count   <= '0;
`endif
        end else begin
            state_q <= state_n;

            if ((state_q == ST_INIT || state_q == ST_FLUSH) && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (state_n == ST_FLUSH && state_q != ST_FLUSH)
                cnt_q <= FLUSH_LOAD;

            if (take_src) begin
                src_idx_q <= req_idx;
                is_trap_q <= 1'b1;
                id_q      <= sel_id;
                code_q    <= sel_code;
                tval_q    <= sel_tval;
            end
            if (take_ret) begin
                is_trap_q <= 1'b0;
                ret_pc_q  <= ret_pc;
            end

            // Outputs are registered against the next state so they
            // align exactly with the state they decode.
            init_clear  <= (state_n == ST_INIT);
            fetch_hold  <= (state_n == ST_INIT);
            issue_hold  <= (state_n != ST_IDLE);
            busy        <= (state_n != ST_IDLE);
            fetch_flush <= (state_n == ST_FLUSH);
            pc_override <= (state_n == ST_REDIRECT);
            exc_valid   <= (state_n == ST_REDIRECT) && is_trap_q;

`ifdef GC_TRAP_STATS_EN
            if (state_q == ST_REDIRECT) begin
                if (is_trap_q) trap_count <= trap_count + 32'd1;
                else           ret_count  <= ret_count + 32'd1;
            end
`endif
        end
    end

    // trap_vec is taken live during REDIRECT; record outputs are zero elsewhere
    assign redirect_pc = pc_override ? (is_trap_q ? trap_vec : ret_pc_q) : '0;
    assign exc_code    = exc_valid ? code_q : '0;
    assign exc_tval    = exc_valid ? tval_q : '0;
    assign exc_id      = exc_valid ? id_q   : '0;

endmodule

// File: tb/tb_gc_trap_controller.sv
// tb_gc_trap_controller: table-driven arbitration vectors with a redirect
// scoreboard, plus hand-written preemption and reset-in-flush sequences.
module tb_gc_trap_controller;

    localparam int NS = 4;
    localparam int IW = 3;
    localparam int CW = 5;
    localparam int XL = 32;

    logic              clk;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS*IW-1:0]  src_id;
    logic [NS*CW-1:0]  src_code;
    logic [NS*XL-1:0]  src_tval;
    logic [NS-1:0]     src_ack;
    logic              ret_req;
    logic [XL-1:0]     ret_pc;
    logic              ret_ack;
    logic [XL-1:0]     trap_vec;
    logic              drain_done;
    logic              init_clear;
    logic              fetch_hold;
    logic              issue_hold;
    logic              fetch_flush;
    logic              pc_override;
    logic [XL-1:0]     redirect_pc;
    logic              exc_valid;
    logic [CW-1:0]     exc_code;
    logic [XL-1:0]     exc_tval;
    logic [IW-1:0]     exc_id;
    logic              busy;
`ifdef GC_TRAP_STATS_EN
    logic [31:0]       trap_count;
    logic [31:0]       ret_count;
`endif

    gc_trap_controller #(
        .NUM_SRC(NS), .ID_W(IW), .CODE_W(CW), .XLEN(XL),
        .INIT_CLEAR_DEPTH(8), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_id(src_id), .src_code(src_code),
        .src_tval(src_tval), .src_ack(src_ack),
        .ret_req(ret_req), .ret_pc(ret_pc), .ret_ack(ret_ack),
        .trap_vec(trap_vec), .drain_done(drain_done),
        .init_clear(init_clear), .fetch_hold(fetch_hold), .issue_hold(issue_hold),
        .fetch_flush(fetch_flush), .pc_override(pc_override),
        .redirect_pc(redirect_pc), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_tval(exc_tval), .exc_id(exc_id),
        .busy(busy)
`ifdef GC_TRAP_STATS_EN
        , .trap_count(trap_count), .ret_count(ret_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Per-source record contents driven on the packed buses
    logic [CW-1:0] code_tab [NS];
    logic [XL-1:0] tval_tab [NS];
    logic [IW-1:0] id_tab   [NS];

    typedef struct {
        logic [XL-1:0] pc;
        logic          ev;
        logic [CW-1:0] code;
        logic [XL-1:0] tval;
        logic [IW-1:0] id;
        int unsigned   cyc;
    } exp_t;
    exp_t sbq [$];
    exp_t e;

    typedef struct {
        logic [NS-1:0] sv;
        logic          rr;
        logic [NS-1:0] ack;
        logic          rack;
    } vec_t;
    vec_t tab [6];

    logic [NS-1:0] pend_src;
    logic          pend_ret;
    int unsigned   exp_traps;
    int unsigned   exp_rets;
    logic          pc_prev = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void bound_fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_trap(input int idx);
        exp_t x;
        x.pc   = trap_vec;
        x.ev   = 1'b1;
        x.code = code_tab[idx];
        x.tval = tval_tab[idx];
        x.id   = id_tab[idx];
        x.cyc  = cyc + 4;
        sbq.push_back(x);
        exp_traps++;
    endtask

    task automatic push_ret();
        exp_t x;
        x.pc   = ret_pc;
        x.ev   = 1'b0;
        x.code = '0;
        x.tval = '0;
        x.id   = '0;
        x.cyc  = cyc + 3;
        sbq.push_back(x);
        exp_rets++;
    endtask

    // Count INIT cycles after reset release; no source may be accepted meanwhile
    task automatic check_init();
        int unsigned k;
        k = 0;
        #1;
        while (init_clear && k < 40) begin
            check("init_no_ack", src_ack, '0);
            k++;
            step();
            #1;
        end
        check("init_clear_cycles", k, 8);
        check("post_init_busy", busy, 0);
        check("post_init_holds", {fetch_hold, issue_hold, fetch_flush}, 3'b000);
    endtask

    // Drive pending requests until all are accepted, checking acks against the
    // priority model, then wait for every scoreboarded redirect to retire
    task automatic serve();
        int unsigned n;
        int          fi;
        logic [NS-1:0] ea;
        logic        er;
        n = 0;
        drain_done = 1'b1;
        while ((pend_src != '0 || pend_ret) && n < 100) begin
            src_valid = pend_src;
            ret_req   = pend_ret;
            #1;
            ea = '0;
            er = 1'b0;
            fi = -1;
            if (!busy) begin
                for (int i = 0; i < NS; i++)
                    if (pend_src[i] && fi < 0) fi = i;
                if (fi >= 0) ea[fi] = 1'b1;
                else         er = pend_ret;
            end
            check("src_ack", src_ack, ea);
            check("ret_ack", ret_ack, er);
            if (fi >= 0) begin
                push_trap(fi);
                pend_src[fi] = 1'b0;
            end else if (er) begin
                push_ret();
                pend_ret = 1'b0;
            end
            step();
            n++;
        end
        src_valid = pend_src;
        ret_req   = pend_ret;
        if (n >= 100) bound_fail("serve_accept");
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) bound_fail("serve_complete");
        check("idle_outputs", {init_clear, fetch_hold, issue_hold, fetch_flush}, 4'b0000);
    endtask

    // Redirect monitor: pops the scoreboard on every pc_override pulse
    always @(negedge clk) begin
        if (rst) begin
            pc_prev = 1'b0;
        end else begin
            if (pc_prev) check("pc_override_single_pulse", pc_override, 0);
            if (pc_override) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: redirect_pc 0x%0h, expected no redirect (cycle %0d)",
                             redirect_pc, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("redirect_pc", redirect_pc, e.pc);
                    check("exc_valid", exc_valid, e.ev);
                    check("redirect_cycle", cyc, e.cyc);
                    check("redirect_issue_hold", issue_hold, 1);
                    if (e.ev) begin
                        check("exc_code", exc_code, e.code);
                        check("exc_tval", exc_tval, e.tval);
                        check("exc_id", exc_id, e.id);
                    end
                end
            end else if (exc_valid) begin
                check("exc_valid_without_redirect", exc_valid, 0);
            end
            pc_prev = pc_override;
        end
    end

    initial begin
        #100000;
        bound_fail("global_watchdog");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        code_tab[0] = 5'd2;   tval_tab[0] = 32'h0000_0500; id_tab[0] = 3'd1;
        code_tab[1] = 5'd4;   tval_tab[1] = 32'h0000_1000; id_tab[1] = 3'd2;
        code_tab[2] = 5'd13;  tval_tab[2] = 32'h0000_2abc; id_tab[2] = 3'd5;
        code_tab[3] = 5'd21;  tval_tab[3] = 32'hdead_0004; id_tab[3] = 3'd7;

        //            src_valid  ret  first ack  ret_ack
        tab[0] = '{sv: 4'b0110, rr: 1'b0, ack: 4'b0010, rack: 1'b0};
        tab[1] = '{sv: 4'b1000, rr: 1'b1, ack: 4'b1000, rack: 1'b0};
        tab[2] = '{sv: 4'b0000, rr: 1'b1, ack: 4'b0000, rack: 1'b1};
        tab[3] = '{sv: 4'b1111, rr: 1'b0, ack: 4'b0001, rack: 1'b0};
        tab[4] = '{sv: 4'b1010, rr: 1'b1, ack: 4'b0010, rack: 1'b0};
        tab[5] = '{sv: 4'b0100, rr: 1'b0, ack: 4'b0100, rack: 1'b0};

        for (int i = 0; i < NS; i++) begin
            src_id[i*IW +: IW]   = id_tab[i];
            src_code[i*CW +: CW] = code_tab[i];
            src_tval[i*XL +: XL] = tval_tab[i];
        end

        rst        = 1'b1;
        src_valid  = '0;
        ret_req    = 1'b0;
        ret_pc     = '0;
        trap_vec   = 32'h8000_0100;
        drain_done = 1'b1;
        pend_src   = '0;
        pend_ret   = 1'b0;
        exp_traps  = 0;
        exp_rets   = 0;

        // Reset values
        repeat (3) step();
        #1;
        check("rst_init_clear", init_clear, 1);
        check("rst_fetch_hold", fetch_hold, 1);
        check("rst_issue_hold", issue_hold, 1);
        check("rst_busy", busy, 1);
        check("rst_fetch_flush", fetch_flush, 0);
        check("rst_pc_override", pc_override, 0);
        check("rst_exc_valid", exc_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_exc_record", {exc_code, exc_tval, exc_id}, 0);

        // Release with a source already pending: it must wait out init-clear
        src_valid = 4'b0001;
        rst = 1'b0;
        check_init();
        pend_src = 4'b0001;
        serve();

        // Arbitration table: first accept checked against the table, the rest
        // of each pattern drained through the model and scoreboard
        for (int i = 0; i < 6; i++) begin
            trap_vec  = 32'h8000_0100 + 32'(i) * 32'h40;
            ret_pc    = 32'h0000_1F00 + 32'(i) * 32'h100;
            src_valid = tab[i].sv;
            ret_req   = tab[i].rr;
            #1;
            check($sformatf("tab%0d_src_ack", i), src_ack, tab[i].ack);
            check($sformatf("tab%0d_ret_ack", i), ret_ack, tab[i].rack);
            pend_src = tab[i].sv;
            pend_ret = tab[i].rr;
            serve();
        end

        // Preemption in DRAIN: src 2 latched, src 3 ignored, src 0 replaces it
        trap_vec   = 32'h8000_0400;
        drain_done = 1'b0;
        src_valid  = 4'b0100;
        #1;
        check("pre_ack_src2", src_ack, 4'b0100);
        step();
        src_valid = 4'b1000;
        #1;
        check("pre_src3_not_acked", src_ack, 4'b0000);
        check("drain_issue_hold", issue_hold, 1);
        check("drain_no_flush", {fetch_flush, fetch_hold}, 2'b00);
        repeat (2) begin
            step();
            #1;
            check("pre_src3_still_not_acked", src_ack, 4'b0000);
        end
        step();
        src_valid  = 4'b1001;
        drain_done = 1'b1;
        #1;
        check("pre_ack_src0", src_ack, 4'b0001);
        push_trap(0);
        step();
        pend_src = 4'b1000;
        serve();

`ifdef GC_TRAP_STATS_EN
        check("stats_trap_count", trap_count, exp_traps);
        check("stats_ret_count", ret_count, exp_rets);
`endif

        // Reset during FLUSH discards the accepted trap
        trap_vec  = 32'h8000_0800;
        src_valid = 4'b0010;
        #1;
        check("rstflush_ack", src_ack, 4'b0010);
        step();
        src_valid = '0;
        step();
        #1;
        check("rstflush_in_flush", fetch_flush, 1);
        rst = 1'b1;
        #1;
        check("rstflush_init_clear", init_clear, 1);
        check("rstflush_no_flush", fetch_flush, 0);
        check("rstflush_no_override", pc_override, 0);
        check("rstflush_busy", busy, 1);
        step();
        rst       = 1'b0;
        exp_traps = 0;
        exp_rets  = 0;
        check_init();

        // Operation resumes cleanly with a return
        ret_pc   = 32'h0000_3000;
        pend_ret = 1'b1;
        serve();

`ifdef GC_TRAP_STATS_EN
        check("stats_after_rst_trap_count", trap_count, exp_traps);
        check("stats_after_rst_ret_count", ret_count, exp_rets);
`endif

        if (sbq.size() != 0) bound_fail("scoreboard_leftover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
